// File: rtl/stream_rescale_pkg.sv
// stream_rescale_pkg: shared types for the stream rescale arbiter slice.
// Arbiter FSM state and the source-id width helper.
package stream_rescale_pkg;

    localparam int MIN_SRC_ID_W = 1;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_t;

    function automatic int src_id_w(input int n_src);
        return (n_src > 1) ? $clog2(n_src) : MIN_SRC_ID_W;
    endfunction

endpackage

// File: rtl/stream_rr_pick.sv
// stream_rr_pick: combinational round-robin requester picker.
// Scans from last_grant+1 (mod N_SRC); first active request wins.
module stream_rr_pick
    import stream_rescale_pkg::*;
#(
    parameter int N_SRC = 4,
    localparam int ID_W = src_id_w(N_SRC)
) (
    input  logic [N_SRC-1:0] req_i,
    input  logic [ID_W-1:0]  last_grant_i,
    output logic [ID_W-1:0]  grant_o,
    output logic             any_req_o
);

    int idx;

    // Walk the sources in rotation order, latching the first requester
    always_comb begin
        grant_o   = '0;
        any_req_o = 1'b0;
        idx       = 0;
        for (int i = 1; i <= N_SRC; i++) begin
            idx = (int'(last_grant_i) + i) % N_SRC;
            if (!any_req_o && req_i[idx]) begin
                any_req_o = 1'b1;
                grant_o   = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/stream_rescale_arbiter.sv
// stream_rescale_arbiter: packet-locked round-robin mux in front of a rescaler.
// Optional per-source packet counters under STREAM_RESCALE_ARB_STATS_EN.
module stream_rescale_arbiter
    import stream_rescale_pkg::*;
#(
    parameter int N_SRC        = 4,
    parameter int T_DATA_WIDTH = 1,
    parameter int KEEP_WIDTH   = 3,
    parameter int CNT_WIDTH    = 16,
    localparam int SRC_ID_W    = src_id_w(N_SRC)
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic [N_SRC-1:0][KEEP_WIDTH-1:0][T_DATA_WIDTH-1:0] s_data_in,
    input  logic [N_SRC-1:0][KEEP_WIDTH-1:0]               s_keep_in,
    input  logic [N_SRC-1:0]                               s_last_in,
    input  logic [N_SRC-1:0]                               s_valid_in,
    output logic [N_SRC-1:0]                               s_ready_out,
    output logic [KEEP_WIDTH-1:0][T_DATA_WIDTH-1:0]        m_data_out,
    output logic [KEEP_WIDTH-1:0]                          m_keep_out,
    output logic                                           m_last_out,
    output logic                                           m_valid_out,
    input  logic                                           m_ready_in,
    output logic [SRC_ID_W-1:0]                            m_src_id_out,
    output logic                                           busy_out,
    output logic [N_SRC-1:0][CNT_WIDTH-1:0]                pkt_cnt_out
);

    arb_state_t          state_q, state_d;
    logic [SRC_ID_W-1:0] grant_q, grant_d;
    logic [SRC_ID_W-1:0] last_grant_q, last_grant_d;
    logic [SRC_ID_W-1:0] pick_id;
    logic                any_req;
    logic                last_hs;

    stream_rr_pick #(
        .N_SRC (N_SRC)
    ) u_pick (
        .req_i        (s_valid_in),
        .last_grant_i (last_grant_q),
        .grant_o      (pick_id),
        .any_req_o    (any_req)
    );

    // State and grant registers; last_grant resets so source 0 wins first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= SRC_ID_W'(N_SRC - 1);
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Arbitrate in IDLE, pass the granted stream through in XFER
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        m_data_out   = '0;
        m_keep_out   = '0;
        m_last_out   = 1'b0;
        m_valid_out  = 1'b0;
        s_ready_out  = '0;
        m_src_id_out = '0;
        busy_out     = 1'b0;
        last_hs      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d = pick_id;
                    state_d = XFER;
                end
            end
            XFER: begin
                busy_out             = 1'b1;
                m_src_id_out         = grant_q;
                m_data_out           = s_data_in[grant_q];
                m_keep_out           = s_keep_in[grant_q];
                m_last_out           = s_last_in[grant_q];
                m_valid_out          = s_valid_in[grant_q];
                s_ready_out[grant_q] = m_ready_in;
                last_hs = s_valid_in[grant_q] && m_ready_in
                          && s_last_in[grant_q];
                if (last_hs) begin
                    last_grant_d = grant_q;
                    state_d      = IDLE;
                end
            end
        endcase
    end

`ifdef STREAM_RESCALE_ARB_STATS_EN
    logic [N_SRC-1:0][CNT_WIDTH-1:0] cnt_q, cnt_d;

    // Saturating count of completed packets for the granted source
    always_comb begin
        cnt_d = cnt_q;
        if (last_hs && (cnt_q[grant_q] != '1)) begin
            cnt_d[grant_q] = cnt_q[grant_q] + CNT_WIDTH'(1);
        end
    end

    // Counter storage, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign pkt_cnt_out = cnt_q;
`else
    assign pkt_cnt_out = '0;
`endif

endmodule
